// File: rtl/sprite_ram_loader.sv
// sprite_ram_loader: packs a byte stream into 1bpp sprite rows and writes them into
// the back bank of a double-buffered sprite RAM, swapping banks only on frame_sync.
module sprite_ram_loader #(
    parameter int COLS = 40,
    parameter int ROWS = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              frame_sync,
    input  logic [4:0]        rd_addr,
    output logic [COLS-1:0]   rd_data,
    output logic              busy,
    output logic              done
);
    localparam int BPR    = COLS / 8;
    localparam int ADDR_W = 5;
    localparam int BCW    = $clog2(BPR + 1);

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

    state_t            state_q;
    logic              active_q;
    logic              done_q;
    logic [ADDR_W-1:0] row_cnt_q;
    logic [BCW-1:0]    byte_cnt_q;
    logic [COLS-1:0]   row_q;
    logic [COLS-1:0]   row_d;
    logic [COLS-1:0]   bank_q [2][ROWS];
    logic              row_end;

    assign row_end = byte_cnt_q == BCW'(BPR - 1);

    // The row being assembled, including the byte offered this cycle
    always_comb begin
        row_d = row_q;
        row_d[COLS-1-8*int'(byte_cnt_q) -: 8] = in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            row_cnt_q  <= '0;
            byte_cnt_q <= '0;
            row_q      <= '0;
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < ROWS; r++)
                    bank_q[b][r] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    state_q    <= LOAD;
                    row_cnt_q  <= '0;
                    byte_cnt_q <= '0;
                    row_q      <= '0;
                end
                LOAD: if (in_valid) begin
                    row_q <= row_d;
                    if (row_end) begin
                        bank_q[!active_q][row_cnt_q] <= row_d;
                        byte_cnt_q <= '0;
                        row_cnt_q  <= row_cnt_q + 1'b1;
                        if (row_cnt_q == ADDR_W'(ROWS - 1)) state_q <= COMMIT;
                    end else begin
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                    end
                end
                COMMIT: if (frame_sync) begin
                    active_q <= !active_q;
                    done_q   <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready = state_q == LOAD;
    assign busy     = state_q != IDLE;
    assign done     = done_q;
    assign rd_data  = (int'(rd_addr) < ROWS) ? bank_q[active_q][rd_addr] : '0;
endmodule

// File: tb/tb_sprite_ram_loader.sv
// tb_sprite_ram_loader: directed, table-driven checks of the sprite RAM loader
// covering reset, full loads, backpressure, ignored controls and bank swapping.
module tb_sprite_ram_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        frame_sync = 1'b0;
    logic [4:0]  rd_addr = '0;
    logic [39:0] rd_data;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [39:0] exp;
    } vec_t;

    vec_t ramp_tbl [8];

    sprite_ram_loader #(.COLS(40), .ROWS(24)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .frame_sync(frame_sync),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_rows(input string name, input logic [39:0] row_val);
        for (int a = 0; a < 32; a++) begin
            rd_addr = 5'(a);
            #1;
            chk($sformatf("%s[%0d]", name, a), rd_data, (a < 24) ? row_val : 40'h0);
        end
    endtask

    task automatic chk_ramp(input string name);
        for (int i = 0; i < 8; i++) begin
            rd_addr = ramp_tbl[i].addr;
            #1;
            chk($sformatf("%s[%0d]", name, ramp_tbl[i].addr), rd_data, ramp_tbl[i].exp);
        end
    endtask

    // Streams 120 bytes; ff selects 0xFF bytes instead of the ramp i[7:0].
    task automatic load(input bit ff, input bit bp, input bit noise, input bit fs_final,
                        output int ready_cycles);
        int sent = 0;
        int cyc = 0;
        logic rdy;
        ready_cycles = 0;
        start = 1'b1;
        tick;
        start = 1'b0;
        while (sent < 120 && cyc < 1000) begin
            in_valid   = bp ? (cyc % 2 == 0) : 1'b1;
            in_data    = ff ? 8'hFF : 8'(sent);
            start      = noise && cyc == 5;
            frame_sync = (noise && cyc == 10) || (fs_final && sent == 119 && in_valid);
            rdy = in_ready;
            if (rdy) ready_cycles++;
            tick;
            if (rdy && in_valid) sent++;
            cyc++;
        end
        in_valid   = 1'b0;
        start      = 1'b0;
        frame_sync = 1'b0;
        in_data    = 8'h5A;
        chk("transfers", sent, 120);
    endtask

    task automatic commit_swap;
        chk("commit_busy", busy, 1);
        chk("commit_ready", in_ready, 0);
        chk("commit_done", done, 0);
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        chk("commit_start_ignored", busy, 1);
        chk("commit_ready2", in_ready, 0);
        frame_sync = 1'b1;
        tick;
        frame_sync = 1'b0;
        chk("swap_done", done, 1);
        chk("swap_busy", busy, 0);
        chk("swap_ready", in_ready, 0);
    endtask

    initial begin
        int rc;
        ramp_tbl[0] = '{5'd0,  40'h0001020304};
        ramp_tbl[1] = '{5'd1,  40'h0506070809};
        ramp_tbl[2] = '{5'd2,  40'h0A0B0C0D0E};
        ramp_tbl[3] = '{5'd12, 40'h3C3D3E3F40};
        ramp_tbl[4] = '{5'd23, 40'h7374757677};
        ramp_tbl[5] = '{5'd24, 40'h0};
        ramp_tbl[6] = '{5'd31, 40'h0};
        ramp_tbl[7] = '{5'd22, 40'h6E6F707172};

        #12;
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk_rows("rst_rd", 40'h0);
        rst_n = 1'b1;
        tick;

        // Load A: ramp, no backpressure
        load(1'b0, 1'b0, 1'b0, 1'b0, rc);
        chk("a_ready_cycles", rc, 120);
        chk_rows("a_pre_swap", 40'h0);
        commit_swap;
        chk_ramp("a_rows");
        tick;
        chk("a_done_once", done, 0);

        // Load B: all 0xFF with start/frame_sync noise during LOAD and on the last transfer
        load(1'b1, 1'b0, 1'b1, 1'b1, rc);
        chk("b_ready_cycles", rc, 120);
        chk_ramp("b_pre_swap");
        commit_swap;
        chk_rows("b_rows", 40'hFFFFFFFFFF);

        // Load C starts in the done cycle, ramp with alternating in_valid
        load(1'b0, 1'b1, 1'b0, 1'b0, rc);
        chk("c_ready_cycles", rc, 239);
        chk_rows("c_pre_swap", 40'hFFFFFFFFFF);
        commit_swap;
        chk_ramp("c_rows");
        tick;

        // Reset in the middle of a load discards everything
        start = 1'b1;
        tick;
        start = 1'b0;
        in_valid = 1'b1;
        repeat (7) tick;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk_rows("mid_rst_rd", 40'h0);
        in_valid = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        chk("post_rst_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
